// File: rtl/instruction_loader.sv
// instruction_loader
//   Boot-time program loader. Receives a length-prefixed byte stream
//   (N high byte, N low byte, 4*N data bytes MSB-first, optional checksum)
//   over a valid/ready handshake, packs big-endian 32-bit words and writes
//   them to instruction RAM from address 0. Holds the core in reset while
//   loading or after an error.
//
//   Build option: define LOADER_CHECKSUM_EN to require a trailing byte equal
//   to the modulo-256 sum of all data bytes (adds the CHECK state).
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle pulse, begins a session from IDLE/DONE/ERR
//   byte_data   stream byte
//   byte_valid  byte_data valid
//   byte_ready  loader accepts a byte this cycle
//   wr_en       one-cycle instruction RAM write strobe
//   wr_addr     write word address (holds last value outside a write)
//   wr_data     write word (holds last value outside a write)
//   cpu_hold    processor reset request
//   done        successful load, level until next start
//   error       aborted load, level until next start
//   word_count  words written in this session
module instruction_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 151
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q;
  logic [31:0]       asm_q;
  logic [1:0]        idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;

  logic              accept;
  logic              start_take;
  logic [15:0]       len_full;
  logic [15:0]       count_next;
  logic              last_word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign accept     = byte_valid && byte_ready;
  assign start_take = start && (state_q == S_IDLE || state_q == S_DONE ||
                                state_q == S_ERR);
  assign len_full   = {len_q[15:8], byte_data};
  assign count_next = 16'(count_q) + 16'd1;
  assign last_word  = (count_next == len_q);
  assign word_count = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_full == 16'd0 || len_full > 16'(DEPTH)) state_d = S_ERR;
          else                                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = (byte_data == sum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_d = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_d = S_LEN_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The outgoing word/address are captured on the fourth byte so they are
  // valid throughout WRITE and then simply hold until the next write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else if (start_take) begin
      idx_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_LEN_HI: if (accept) len_q[15:8] <= byte_data;
        S_LEN_LO: if (accept) len_q[7:0]  <= byte_data;
        S_DATA: begin
          if (accept) begin
            asm_q[8*(3-int'(idx_q)) +: 8] <= byte_data;
            idx_q <= idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= sum_q + byte_data;
`endif
            if (idx_q == 2'd3) begin
              wr_data <= {asm_q[31:8], byte_data};
              wr_addr <= addr_q;
            end
          end
        end
        S_WRITE: begin
          addr_q  <= addr_q + 1'b1;
          count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 151;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready, wr_en, cpu_hold, done, error;
  logic [ADDR_W-1:0] wr_addr, word_count;
  logic [31:0]       wr_data;

  always #5 clock = ~clock;

  instruction_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the next expected (addr, word).
  always @(negedge clock) begin
    wr_t e;
    if (reset && wr_en) begin
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", wr_data, e.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %0h never accepted", b);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Reference: stream = N(16b BE), words MSB-first, optional checksum byte.
  // ck_adj != 0 corrupts the checksum; mid_start >= 0 pulses start before
  // that data byte index (must be ignored).
  task automatic do_load(input int n, input bit gaps, input logic [7:0] ck_adj,
                         input int mid_start);
    logic [15:0] nl;
    logic [31:0] w;
    logic [7:0]  sum;
    bit          bad;
    nl  = n[15:0];
    sum = 8'd0;
    pulse_start();
    send_byte(nl[15:8], gaps);
    send_byte(nl[7:0], gaps);
    if (n == 0 || n > DEPTH) begin
      check("len_err_error", 32'(error), 32'd1);
      check("len_err_done", 32'(done), 32'd0);
      check("len_err_hold", 32'(cpu_hold), 32'd1);
      check("len_err_ready", 32'(byte_ready), 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        if (mid_start == 4 * i + b) pulse_start();
        sum = sum + w[31-8*b -: 8];
        if (b == 3) exp_q.push_back('{a: ADDR_W'(i), d: w});
        send_byte(w[31-8*b -: 8], gaps);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    bad = (ck_adj != 8'd0);
    send_byte(sum + ck_adj, gaps);
`else
    bad = 1'b0;
    @(posedge clock); #1;
`endif
    check("end_done", 32'(done), 32'(!bad));
    check("end_error", 32'(error), 32'(bad));
    check("end_hold", 32'(cpu_hold), 32'(bad));
    check("end_count", 32'(word_count), 32'(n));
    check("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_data"}, wr_data, 32'd0);
    check({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #12;
    check_reset_outputs("rst");
    reset = 1'b1;
    @(posedge clock); #1;

    // Reference vector
    words.delete();
    words.push_back(32'h5C000052);
    words.push_back(32'h2C630007);
    do_load(2, 1'b0, 8'd0, -1);

    // Bytes after completion must not be consumed
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (3) begin
      @(posedge clock); #1;
      check("no_consume_done", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;

    // Length boundaries
    do_load(0, 1'b0, 8'd0, -1);
    do_load(152, 1'b0, 8'd0, -1);
    fill_random(151);
    do_load(151, 1'b0, 8'd0, -1);

    // Random gaps on byte_valid
    for (int k = 0; k < 4; k++) begin
      int n;
      n = (k == 0) ? 3 : int'($urandom_range(1, 8));
      fill_random(n);
      do_load(n, 1'b1, 8'd0, -1);
    end

    // Start pulsed in the middle of DATA is ignored
    fill_random(3);
    do_load(3, 1'b1, 8'd0, 5);

    // Start after done clears status on the next edge
    pulse_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_count", 32'(word_count), 32'd0);
    check("restart_ready", 32'(byte_ready), 32'd1);
    check("restart_hold", 32'(cpu_hold), 32'd1);

    // Reset after 6 data bytes of an N=2 load
    fill_random(2);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    exp_q.push_back('{a: ADDR_W'(0), d: words[0]});
    for (int b = 0; b < 4; b++) send_byte(words[0][31-8*b -: 8], 1'b0);
    send_byte(words[1][31:24], 1'b0);
    send_byte(words[1][23:16], 1'b0);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_drained", 32'(exp_q.size()), 32'd0);
    #3 reset = 1'b1;
    @(posedge clock); #1;
    fill_random(2);
    do_load(2, 1'b1, 8'd0, -1);

`ifdef LOADER_CHECKSUM_EN
    words.delete();
    words.push_back(32'h01020304);
    do_load(1, 1'b0, 8'd1, -1);
    do_load(1, 1'b0, 8'd0, -1);
    fill_random(4);
    do_load(4, 1'b1, 8'd0, -1);
`endif

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
